aes_host_tx: RTL and testbench

//  Host-side byte transmitter that drives the chip's 9-bit rx bus: user_data[7:0] plus strobe shi.

---
 rtl/aes_host_tx_pkg.sv | 15 +
 rtl/aes_host_tx_if.sv | 22 ++
 rtl/aes_host_tx_word_fifo.sv | 63 ++++++
 rtl/aes_host_tx.sv | 136 +++++++++++++
 tb/tb_aes_host_tx.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_host_tx_pkg.sv
// aes_host_tx shared types: FSM states and word/byte geometry.
// Also used by the chip-side 8->32 input assembler.
package aes_host_tx_pkg;

  localparam int AES_BYTES_PER_WORD = 4;
  localparam int AES_WORD_W = 32;
  localparam int AES_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/aes_host_tx_if.sv
// aes_host_tx word port: 32-bit word with valid/ready handshake.
// master drives word/valid, slave returns ready.
interface aes_host_tx_if;
  import aes_host_tx_pkg::*;

  logic [AES_WORD_W-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/aes_host_tx_word_fifo.sv
// aes_word_fifo: DEPTH x W word FIFO, sync active-low reset.
// Full/empty come from an explicit occupancy count.
module aes_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // power-of-two depth: pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/aes_host_tx.sv
// aes_host_tx: buffers 32-bit words, sends them MSB byte first on
// user_data/shi with a programmable gap. AES_HOST_TX_STATS_EN adds sent_cnt.
module aes_host_tx
  import aes_host_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_host_tx_if.slave          wr,
  input  logic [GAP_W-1:0]      gap_cfg,
  output logic [AES_BYTE_W-1:0] user_data,
  output logic                  shi,
  output logic                  busy
`ifdef AES_HOST_TX_STATS_EN
  ,
  output logic [15:0]           sent_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e                state_q, state_d;
  logic [AES_WORD_W-1:0] shreg_q, shreg_d;
  logic [2:0]            idx_q, idx_d;
  logic [GAP_W-1:0]      gap_lat_q, gap_lat_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [AES_BYTE_W-1:0] ud_q, ud_d;
  logic                  shi_q, shi_d;

  logic                  pop;
  logic [AES_WORD_W-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_cnt;

  aes_word_fifo #(
    .DEPTH (DEPTH),
    .W     (AES_WORD_W),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr.word_valid),
    .din_i   (wr.word_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign wr.word_ready = ~fifo_full;
  assign busy = (fifo_cnt != '0) | (state_q != ST_IDLE);
  assign user_data = ud_q;
  assign shi = shi_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    gap_lat_d = gap_lat_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_dout;
          gap_lat_d = gap_cfg;
          idx_d     = 3'd0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        shreg_d = shreg_q << AES_BYTE_W;
        idx_d   = idx_q + 3'd1;
        if (gap_lat_q != '0) begin
          gap_cnt_d = gap_lat_q;
          state_d   = ST_GAP;
        end else if (idx_q == 3'd3) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = (idx_q < 3'd4) ? ST_SEND : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // outputs registered from next state; byte held between strobes
    shi_d = (state_d == ST_SEND);
    ud_d  = shi_d ? shreg_d[AES_WORD_W-1 -: AES_BYTE_W] : ud_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      gap_lat_q <= '0;
      gap_cnt_q <= '0;
      ud_q      <= '0;
      shi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      gap_lat_q <= gap_lat_d;
      gap_cnt_q <= gap_cnt_d;
      ud_q      <= ud_d;
      shi_q     <= shi_d;
    end
  end

`ifdef AES_HOST_TX_STATS_EN
  logic [15:0] sent_q;
  logic        last_byte;

  assign last_byte = shi_d & (idx_d == 3'd3);
  assign sent_cnt  = sent_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sent_q <= '0;
    end else if (last_byte) begin
      sent_q <= sent_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_host_tx.sv
// Self-checking bench for aes_host_tx: randomized words/gaps against a
// timing/byte-order model computed from accept cycles and latched gaps.
module tb_aes_host_tx;
  import aes_host_tx_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP_W = 4;
  localparam int HN = 16384;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [GAP_W-1:0] gap_cfg = '0;
  logic [7:0]       user_data;
  logic             shi;
  logic             busy;
`ifdef AES_HOST_TX_STATS_EN
  logic [15:0]      sent_cnt;
`endif

  aes_host_tx_if wr();

  aes_host_tx #(
    .DEPTH (DEPTH),
    .GAP_W (GAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr.slave),
    .gap_cfg   (gap_cfg),
    .user_data (user_data),
    .shi       (shi),
    .busy      (busy)
`ifdef AES_HOST_TX_STATS_EN
    ,
    .sent_cnt  (sent_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  int          ev_c[$];
  logic [7:0]  ev_b[$];
  int          acc_c[$];
  logic [31:0] acc_w[$];
  int          exp_c[$];
  logic [7:0]  exp_b[$];
  logic [GAP_W-1:0] gap_hist [HN];

  // record strobes, accepted words and the gap seen each cycle
  always @(negedge clk) begin
    gap_hist[cyc % HN] = gap_cfg;
    if (shi === 1'b1) begin
      ev_c.push_back(cyc);
      ev_b.push_back(user_data);
    end
    if (rst === 1'b1 && wr.word_valid === 1'b1 && wr.word_ready === 1'b1) begin
      acc_c.push_back(cyc);
      acc_w.push_back(wr.word_data);
    end
  end

  // word i pops once it is stored and the sender is idle; the gap is
  // whatever gap_cfg held in the pop cycle
  function automatic void build_exp();
    int idle;
    int p;
    int g;
    int first;
    logic [31:0] w;
    exp_c.delete();
    exp_b.delete();
    idle = 0;
    for (int i = 0; i < acc_c.size(); i++) begin
      p = (acc_c[i] + 1 > idle) ? acc_c[i] + 1 : idle;
      g = int'(gap_hist[p % HN]);
      first = p + 1;
      w = acc_w[i];
      for (int k = 0; k < 4; k++) begin
        exp_c.push_back(first + k * (1 + g));
        exp_b.push_back(w[31 - 8 * k -: 8]);
      end
      idle = first + 3 * (1 + g) + g + 1;
    end
  endfunction

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (busy !== 1'b0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s idle_timeout: busy=%b required 0", tag, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_q();
    ev_c.delete();
    ev_b.delete();
    acc_c.delete();
    acc_w.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    wr.word_data = w;
    wr.word_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr.word_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: word %h never accepted", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wr.word_valid = 1'b1;
    wr.word_data = 32'h1234_5678;
    gap_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (shi !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_shi: got %b required 0", shi);
    end
    n_cmp++;
    if (user_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 00", user_data);
    end
    n_cmp++;
    if (wr.word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 1", wr.word_ready);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    @(posedge clk);
    #1;
    wr.word_valid = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || ev_c.size() != 0) begin
      n_fail++;
      $display("FAIL reset_nowrite: busy=%b strobes=%0d required 0/0", busy, ev_c.size());
    end
  endtask

  task automatic test_single();
    int t;
    wait_idle("single");
    clear_q();
    gap_cfg = '0;
    send(32'hA1B2_C3D4);
    wr.word_valid = 1'b0;
    t = (acc_c.size() > 0) ? acc_c[0] : cyc - 1;
    while (cyc < t + 5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_hi: got %b required 1 at t+5", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_lo: got %b required 0 at t+6", busy);
    end
    wait_idle("single");
    build_exp();
    n_cmp++;
    if (ev_c.size() != exp_c.size()) begin
      n_fail++;
      $display("FAIL single_count: got %0d strobes required %0d", ev_c.size(), exp_c.size());
    end
    for (int i = 0; i < exp_c.size() && i < ev_c.size(); i++) begin
      n_cmp++;
      if (ev_c[i] !== exp_c[i] || ev_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL single_byte%0d: got %h@%0d required %h@%0d", i, ev_b[i], ev_c[i], exp_b[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_gap();
    wait_idle("gap");
    clear_q();
    gap_cfg = 4'd3;
    send(32'h0102_0304);
    wr.word_valid = 1'b0;
    @(posedge clk);
    #1;
    gap_cfg = GAP_W'($urandom_range(0, 15));
    wait_idle("gap");
    build_exp();
    n_cmp++;
    if (ev_c.size() != exp_c.size()) begin
      n_fail++;
      $display("FAIL gap_count: got %0d strobes required %0d", ev_c.size(), exp_c.size());
    end
    for (int i = 0; i < exp_c.size() && i < ev_c.size(); i++) begin
      n_cmp++;
      if (ev_c[i] !== exp_c[i] || ev_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL gap_byte%0d: got %h@%0d required %h@%0d", i, ev_b[i], ev_c[i], exp_b[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int off[6];
    off = '{0, 1, 2, 3, 4, 7};
    wait_idle("b2b");
    clear_q();
    gap_cfg = '0;
    for (int i = 0; i < 6; i++) begin
      send($urandom);
    end
    wr.word_valid = 1'b0;
    wait_idle("b2b");
    n_cmp++;
    if (acc_c.size() != 6) begin
      n_fail++;
      $display("FAIL b2b_accepted: got %0d required 6", acc_c.size());
    end
    for (int i = 1; i < 6 && i < acc_c.size(); i++) begin
      n_cmp++;
      if (acc_c[i] - acc_c[0] != off[i]) begin
        n_fail++;
        $display("FAIL b2b_accept%0d: got offset %0d required %0d", i, acc_c[i] - acc_c[0], off[i]);
      end
    end
    build_exp();
    n_cmp++;
    if (ev_c.size() != exp_c.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d strobes required %0d", ev_c.size(), exp_c.size());
    end
    for (int i = 0; i < exp_c.size() && i < ev_c.size(); i++) begin
      n_cmp++;
      if (ev_c[i] !== exp_c[i] || ev_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h@%0d required %h@%0d", i, ev_b[i], ev_c[i], exp_b[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_random();
    bit done;
    wait_idle("rand");
    clear_q();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          wr.word_valid = 1'b0;
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          send($urandom);
        end
        wr.word_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          gap_cfg = GAP_W'($urandom_range(0, 5));
        end
      end
    join
    wait_idle("rand");
    build_exp();
    n_cmp++;
    if (ev_c.size() != exp_c.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d strobes required %0d", ev_c.size(), exp_c.size());
    end
    for (int i = 0; i < exp_c.size() && i < ev_c.size(); i++) begin
      n_cmp++;
      if (ev_c[i] !== exp_c[i] || ev_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL rand_byte%0d: got %h@%0d required %h@%0d", i, ev_b[i], ev_c[i], exp_b[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    wait_idle("rmid");
    clear_q();
    gap_cfg = '0;
    send(32'hDEAD_BEEF);
    wr.word_valid = 1'b0;
    t = (acc_c.size() > 0) ? acc_c[0] : cyc - 1;
    while (cyc < t + 3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (ev_c.size() != 2) begin
      n_fail++;
      $display("FAIL rmid_strobes: got %0d required 2", ev_c.size());
    end else begin
      n_cmp++;
      if (ev_b[0] !== 8'hDE || ev_b[1] !== 8'hAD || ev_c[1] != t + 3) begin
        n_fail++;
        $display("FAIL rmid_bytes: got %h %h@%0d required de ad@%0d", ev_b[0], ev_b[1], ev_c[1], t + 3);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || wr.word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_state: busy=%b ready=%b required 0/1", busy, wr.word_ready);
    end
    clear_q();
    gap_cfg = GAP_W'($urandom_range(0, 3));
    send($urandom);
    wr.word_valid = 1'b0;
    wait_idle("rmid");
    build_exp();
    n_cmp++;
    if (ev_c.size() != exp_c.size()) begin
      n_fail++;
      $display("FAIL rmid_count: got %0d strobes required %0d", ev_c.size(), exp_c.size());
    end
    for (int i = 0; i < exp_c.size() && i < ev_c.size(); i++) begin
      n_cmp++;
      if (ev_c[i] !== exp_c[i] || ev_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL rmid_byte%0d: got %h@%0d required %h@%0d", i, ev_b[i], ev_c[i], exp_b[i], exp_c[i]);
      end
    end
  endtask

`ifdef AES_HOST_TX_STATS_EN
  task automatic test_stats();
    int nb;
    int lim;
    wait_idle("stats");
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sent_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d required 0", sent_cnt);
    end
    gap_cfg = GAP_W'($urandom_range(0, 2));
    nb = 0;
    lim = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) send($urandom);
        wr.word_valid = 1'b0;
      end
      begin
        while (nb < 12 && lim < 500) begin
          @(negedge clk);
          lim++;
          if (shi === 1'b1) begin
            nb++;
            n_cmp++;
            if (sent_cnt !== 16'(nb / 4)) begin
              n_fail++;
              $display("FAIL stats_cnt byte%0d: got %0d required %0d", nb, sent_cnt, nb / 4);
            end
          end
        end
      end
    join
    n_cmp++;
    if (nb != 12) begin
      n_fail++;
      $display("FAIL stats_bytes: got %0d required 12", nb);
    end
  endtask
`endif

  initial begin
    wr.word_valid = 1'b0;
    wr.word_data = '0;
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef AES_HOST_TX_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
